// File: rtl/fp_class_d.sv
// fp_class_d: two-stage pipelined FCLASS.D unit with valid/ready on both sides.
// Define FP_CLASS_D_STATS_EN to build the saturating NaN-result counter.
module fp_class_d #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_a,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic             stat_clr,
    output logic [15:0]      nan_count
);

    logic             s1_valid;
    logic             s1_sign;
    logic             s1_exp_max;
    logic             s1_exp_zero;
    logic             s1_man_zero;
    logic             s1_man_msb;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [9:0]       s2_mask;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_ready;
    logic             s2_ready;
    logic             in_fire;
    logic             s1_move;
    logic             out_fire;
    logic [9:0]       class_mask;

    assign s2_ready = !s2_valid || out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign in_ready = s1_ready;
    assign in_fire  = in_valid && s1_ready;
    assign s1_move  = s1_valid && s2_ready;
    assign out_fire = s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp_max  <= 1'b0;
            s1_exp_zero <= 1'b0;
            s1_man_zero <= 1'b0;
            s1_man_msb  <= 1'b0;
            s1_tag      <= '0;
        end else if (in_fire) begin
            s1_valid    <= 1'b1;
            s1_sign     <= in_a[63];
            s1_exp_max  <= (in_a[62:52] == 11'h7ff);
            s1_exp_zero <= (in_a[62:52] == 11'h000);
            s1_man_zero <= (in_a[51:0] == 52'd0);
            s1_man_msb  <= in_a[51];
            s1_tag      <= in_tag;
        end else if (s1_move) begin
            s1_valid <= 1'b0;
        end
    end

    // Conditions below are mutually exclusive; normal numbers fall to default.
    always_comb begin
        class_mask = '0;
        unique case (1'b1)
            s1_exp_max && s1_man_zero:
                class_mask = s1_sign ? 10'h001 : 10'h080;
            s1_exp_max && !s1_man_zero && s1_man_msb:
                class_mask = 10'h200;
            s1_exp_max && !s1_man_zero && !s1_man_msb:
                class_mask = 10'h100;
            s1_exp_zero && s1_man_zero:
                class_mask = s1_sign ? 10'h008 : 10'h010;
            s1_exp_zero && !s1_man_zero:
                class_mask = s1_sign ? 10'h004 : 10'h020;
            default:
                class_mask = s1_sign ? 10'h002 : 10'h040;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_mask  <= '0;
            s2_tag   <= '0;
        end else if (s1_move) begin
            s2_valid <= 1'b1;
            s2_mask  <= class_mask;
            s2_tag   <= s1_tag;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = {54'd0, s2_mask};
    assign out_tag    = s2_tag;

`ifdef FP_CLASS_D_STATS_EN
    logic [15:0] nan_cnt;
    logic        nan_out;

    assign nan_out = out_fire && (s2_mask[8] || s2_mask[9]);

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            nan_cnt <= '0;
        end else if (nan_out && nan_cnt != 16'hffff) begin
            nan_cnt <= nan_cnt + 16'd1;
        end
    end

    assign nan_count = nan_cnt;
`else
    logic unused_stat_clr;

    assign unused_stat_clr = stat_clr;
    assign nan_count       = '0;
`endif

endmodule

// File: tb/tb_fp_class_d.sv
// tb_fp_class_d: directed class vectors, backpressure, reset flush,
// NaN statistics and random handshake traffic against a reference classifier.
module tb_fp_class_d;

    localparam int TAG_W = 5;

    typedef struct {
        logic [9:0]       res;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_a = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             stat_clr = 1'b0;
    logic [15:0]      nan_count;

    logic             man_rdy = 1'b1;
    logic             rnd_rdy = 1'b1;
    logic             rnd_en = 1'b0;
    logic             lat_chk = 1'b0;
    logic [9:0]       cur_exp = '0;
    int               cyc = 0;
    int               n_chk = 0;
    int               n_fail = 0;
    exp_t             exp_q[$];

    assign out_ready = rnd_en ? rnd_rdy : man_rdy;

    fp_class_d #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_tag   (out_tag),
        .stat_clr  (stat_clr),
        .nan_count (nan_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] ref_class(input logic [63:0] a);
        logic        s;
        logic [10:0] e;
        logic [51:0] m;
        s = a[63];
        e = a[62:52];
        m = a[51:0];
        if (e == 11'h7ff) begin
            if (m == 0) return s ? 10'h001 : 10'h080;
            if (a[51]) return 10'h200;
            return 10'h100;
        end
        if (e == 0) begin
            if (m == 0) return s ? 10'h008 : 10'h010;
            return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e.res = cur_exp;
            e.tag = in_tag;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", out_result, {54'd0, e.res});
                check("tag", {59'd0, out_tag}, {59'd0, e.tag});
                if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
            end
        end
    end

    task automatic send(input logic [63:0] a, input logic [9:0] e,
                        input logic [TAG_W-1:0] t);
        bit acc = 0;
        in_a     = a;
        in_tag   = t;
        cur_exp  = e;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) check("in_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0)
            check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    logic [63:0] vec_a [10];
    logic [9:0]  vec_e [10];

    initial begin
        vec_a[0] = 64'hFFF0000000000000; vec_e[0] = 10'h001;
        vec_a[1] = 64'hBFF0000000000000; vec_e[1] = 10'h002;
        vec_a[2] = 64'h800FFFFFFFFFFFFF; vec_e[2] = 10'h004;
        vec_a[3] = 64'h8000000000000000; vec_e[3] = 10'h008;
        vec_a[4] = 64'h0000000000000000; vec_e[4] = 10'h010;
        vec_a[5] = 64'h0000000000000001; vec_e[5] = 10'h020;
        vec_a[6] = 64'h3FF0000000000000; vec_e[6] = 10'h040;
        vec_a[7] = 64'h7FF0000000000000; vec_e[7] = 10'h080;
        vec_a[8] = 64'h7FF0000000000001; vec_e[8] = 10'h100;
        vec_a[9] = 64'hFFF8000000000000; vec_e[9] = 10'h200;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", {59'd0, out_tag}, 64'd0);
        check("rst_nan_count", {48'd0, nan_count}, 64'd0);
        @(posedge clk);
        #1;

        // every class back to back, latency checked
        lat_chk = 1'b1;
        for (int i = 0; i < 10; i++)
            send(vec_a[i], vec_e[i], TAG_W'(i + 3));
        drain();
        lat_chk = 1'b0;

        // backpressure
        man_rdy = 1'b0;
        send(64'h3FF0000000000000, 10'h040, 5'd1);
        send(64'h8000000000000000, 10'h008, 5'd2);
        in_a     = 64'h7FF8000000000000;
        in_tag   = 5'd3;
        cur_exp  = 10'h200;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_result", out_result, 64'h040);
            check("stall_tag", {59'd0, out_tag}, 64'd1);
        end
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(negedge clk);
        check("unstall_in_ready", {63'd0, in_ready}, 64'd1);
        check("unstall_valid0", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("unstall_valid1", {63'd0, out_valid}, 64'd1);
        @(negedge clk);
        check("unstall_valid2", {63'd0, out_valid}, 64'd1);
        drain();

        // reset with two operands in flight
        man_rdy = 1'b0;
        send(64'h0000000000000001, 10'h020, 5'd7);
        send(64'hBFF0000000000000, 10'h002, 5'd8);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(64'h7FF0000000000000, 10'h080, 5'd9);
        drain();

        // NaN statistics
        send(64'h7FF8000000000000, 10'h200, 5'd10);
        send(64'h3FF0000000000000, 10'h040, 5'd11);
        send(64'hFFF8000000000001, 10'h200, 5'd12);
        send(64'h4000000000000000, 10'h040, 5'd13);
        send(64'h7FFC000000000000, 10'h200, 5'd14);
        drain();
`ifdef FP_CLASS_D_STATS_EN
        check("nan_count3", {48'd0, nan_count}, 64'd3);
`else
        check("nan_count3", {48'd0, nan_count}, 64'd0);
`endif
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        check("nan_clr", {48'd0, nan_count}, 64'd0);

        // random handshake traffic
        rnd_en = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            logic        s;
            logic [10:0] e;
            logic [51:0] m;
            logic [63:0] a;
            s = 1'($urandom_range(0, 1));
            e = 11'($urandom);
            m = {20'($urandom), 32'($urandom)};
            case ($urandom_range(0, 5))
                0: e = 11'h7ff;
                1: e = 11'h000;
                2: begin e = 11'h000; m = '0; end
                3: begin e = 11'h7ff; m = '0; end
                4: begin e = 11'h7ff; m[51] = 1'b0; m[0] = 1'b1; end
                default: ;
            endcase
            a = {s, e, m};
            send(a, ref_class(a), TAG_W'($urandom));
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        rnd_en = 1'b0;

`ifdef FP_CLASS_D_STATS_EN
        // saturation
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
        for (int n = 0; n < 65534; n++)
            send(64'h7FF8000000000000, 10'h200, TAG_W'(n));
        drain();
        check("nan_fffe", {48'd0, nan_count}, 64'hfffe);
        send(64'h7FF0000000000001, 10'h100, 5'd1);
        send(64'hFFF8000000000000, 10'h200, 5'd2);
        drain();
        check("nan_sat", {48'd0, nan_count}, 64'hffff);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
